armleocpu_mem_arbiter: RTL and testbench
========================================

ARMLEOCPU_MEM_ARBITER -- requirements
Module: armleocpu_mem_arbiter

Interface
REQ-001 The block SHALL have no parameters; address width 34, data width 32 and burstcount width 5 are fixed.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 mN_address  input  34  master N (N=0 fetch cache, N=1 data cache) word-aligned address.
REQ-005 mN_burstcount  input  5  beats in burst; 0 treated as 1.
REQ-006 mN_read, mN_write  input  1 each  command strobes.
REQ-007 mN_writedata  input  32; mN_byteenable  input  4.
REQ-008 mN_waitrequest  output  1; mN_readdatavalid  output  1; mN_readdata  output  32; mN_response  output  2.
REQ-009 s_address  output  34; s_burstcount  output  5; s_read, s_write  output  1; s_writedata  output  32; s_byteenable  output  4.
REQ-010 s_waitrequest  input  1; s_readdatavalid  input  1; s_readdata  input  32; s_response  input  2 (00 OKAY, 11 error).

Function
REQ-011 States SHALL be IDLE, CMD, RDATA, WDATA; owner register selects master 0 or 1.
REQ-012 IDLE: s_read=s_write=0, both mN_waitrequest=1, both mN_readdatavalid=0.
REQ-013 IDLE with any mN_read|mN_write: register owner, go CMD next cycle (one-cycle arbitration latency).
REQ-014 Simultaneous requests: grant per REQ-029/030; single request is always granted.
REQ-015 CMD: s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable SHALL equal owner's inputs combinationally; owner waitrequest = s_waitrequest; non-owner waitrequest=1.
REQ-016 CMD read accepted (s_read & !s_waitrequest): load remaining = max(burstcount,1), go RDATA.
REQ-017 RDATA: s_read and s_write forced 0; each s_readdatavalid decrements remaining and pulses owner readdatavalid; leave to IDLE on beat where remaining==1.
REQ-018 CMD write accepted: if burstcount<=1 go IDLE, else load remaining = burstcount-1, go WDATA.
REQ-019 WDATA: owner signals forwarded as CMD; each accepted write beat decrements; go IDLE on beat where remaining==1; s_read forced 0.
REQ-020 mN_readdata and mN_response SHALL be s_readdata/s_response broadcast to both; only owner sees readdatavalid.
REQ-021 Error response on any beat SHALL be forwarded unchanged; burst SHALL NOT terminate early.
REQ-022 mN_read and mN_write both high SHALL be treated as read; s_write held 0.
REQ-023 Owner SHALL NOT change before IDLE; a request arriving during a burst waits (waitrequest=1).
REQ-024 s_readdatavalid in IDLE/CMD/WDATA SHALL be ignored (no master sees it).
REQ-025 No outputs SHALL be registered except state/owner/remaining; path s_waitrequest->mN_waitrequest is combinational.

Reset
REQ-026 rst_n low SHALL force state=IDLE, remaining=0, owner=0, last_owner=1 asynchronously.
REQ-027 During/after reset all s_read/s_write=0, mN_waitrequest=1, mN_readdatavalid=0.
REQ-028 Reset mid-burst SHALL abandon the burst; no outstanding beats tracked afterwards.

Configuration
REQ-029 With ARMLEOCPU_ARBITER_ROUND_ROBIN_EN defined: on simultaneous requests grant master != last_owner; last_owner updated at each grant.
REQ-030 Without it: fixed priority, master 1 (data) always wins simultaneous requests; last_owner unused.

Verification
REQ-031 Reset, m0_read=1 addr 0x1000 burst 1 -> s_read seen cycle 2, one readdatavalid to m0 with mem data, IDLE after.
REQ-032 m1 read burst 16 at 0x2000 -> s_read drops after accept, 16 m1 readdatavalid pulses, m0 readdatavalid stays 0.
REQ-033 m1 write burst 4 -> 4 accepted beats forwarded with byteenable 0xF, return IDLE after 4th.
REQ-034 m0 and m1 read same cycle, repeated 4 times -> round-robin: grants 0,1,0,1; without macro: 1,1,1,1.
REQ-035 Memory returns response 11 on beat 2 of 4 -> m0_response=11 that beat, all 4 beats delivered.
REQ-036 rst_n low during RDATA beat 3 of 8 -> immediate IDLE, waitrequest=1, new request served normally.

Source files
------------

// File: rtl/armleocpu_mem_arbiter.sv
// Two-master (fetch cache / data cache) burst arbiter in front of one memory port.
// Define ARMLEOCPU_ARBITER_ROUND_ROBIN_EN for round-robin grant; default build gives master 1 fixed priority.
module armleocpu_mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [33:0] m0_address,
  input  logic [4:0]  m0_burstcount,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic        m0_readdatavalid,
  output logic [31:0] m0_readdata,
  output logic [1:0]  m0_response,

  input  logic [33:0] m1_address,
  input  logic [4:0]  m1_burstcount,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic        m1_readdatavalid,
  output logic [31:0] m1_readdata,
  output logic [1:0]  m1_response,

  output logic [33:0] s_address,
  output logic [4:0]  s_burstcount,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic        s_readdatavalid,
  input  logic [31:0] s_readdata,
  input  logic [1:0]  s_response
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [4:0]  remaining_q, remaining_d;

  logic        m0_req, m1_req, grant;
  logic [33:0] own_address;
  logic [4:0]  own_burstcount, own_bc_eff;
  logic        own_read, own_write;
  logic [31:0] own_writedata;
  logic [3:0]  own_byteenable;
  logic        own_waitrequest, own_readdatavalid;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

`ifdef ARMLEOCPU_ARBITER_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // On a tie the master that did not win last time gets the bus.
  assign grant = (m0_req && m1_req) ? ~last_owner_q : m1_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= 1'b1;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign grant = m1_req;
`endif

  assign own_address    = owner_q ? m1_address    : m0_address;
  assign own_burstcount = owner_q ? m1_burstcount : m0_burstcount;
  assign own_read       = owner_q ? m1_read       : m0_read;
  assign own_write      = owner_q ? m1_write      : m0_write;
  assign own_writedata  = owner_q ? m1_writedata  : m0_writedata;
  assign own_byteenable = owner_q ? m1_byteenable : m0_byteenable;
  assign own_bc_eff     = (own_burstcount == 5'd0) ? 5'd1 : own_burstcount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      remaining_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    remaining_d       = remaining_q;
`ifdef ARMLEOCPU_ARBITER_ROUND_ROBIN_EN
    last_owner_d      = last_owner_q;
`endif
    s_address         = own_address;
    s_burstcount      = own_burstcount;
    s_writedata       = own_writedata;
    s_byteenable      = own_byteenable;
    s_read            = 1'b0;
    s_write           = 1'b0;
    own_waitrequest   = 1'b1;
    own_readdatavalid = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = grant;
`ifdef ARMLEOCPU_ARBITER_ROUND_ROBIN_EN
          last_owner_d = grant;
`endif
          state_d = CMD;
        end
      end

      // Read wins when a master raises both strobes.
      CMD: begin
        s_read          = own_read;
        s_write         = own_write & ~own_read;
        own_waitrequest = s_waitrequest;
        if (own_read && !s_waitrequest) begin
          remaining_d = own_bc_eff;
          state_d     = RDATA;
        end else if (own_write && !s_waitrequest) begin
          if (own_burstcount <= 5'd1) begin
            state_d = IDLE;
          end else begin
            remaining_d = own_burstcount - 5'd1;
            state_d     = WDATA;
          end
        end else if (!own_read && !own_write) begin
          state_d = IDLE;
        end
      end

      RDATA: begin
        own_readdatavalid = s_readdatavalid;
        if (s_readdatavalid) begin
          if (remaining_q <= 5'd1) begin
            remaining_d = 5'd0;
            state_d     = IDLE;
          end else begin
            remaining_d = remaining_q - 5'd1;
          end
        end
      end

      WDATA: begin
        s_write         = own_write;
        own_waitrequest = s_waitrequest;
        if (own_write && !s_waitrequest) begin
          if (remaining_q <= 5'd1) begin
            remaining_d = 5'd0;
            state_d     = IDLE;
          end else begin
            remaining_d = remaining_q - 5'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m0_waitrequest   = owner_q ? 1'b1 : own_waitrequest;
  assign m1_waitrequest   = owner_q ? own_waitrequest : 1'b1;
  assign m0_readdatavalid = owner_q ? 1'b0 : own_readdatavalid;
  assign m1_readdatavalid = owner_q ? own_readdatavalid : 1'b0;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_response      = s_response;
  assign m1_response      = s_response;

endmodule

// File: tb/tb_armleocpu_mem_arbiter.sv
// Self-checking bench for armleocpu_mem_arbiter: cycle vector table, directed burst
// sequences, then randomized traffic against a transaction-level memory model.
module tb_armleocpu_mem_arbiter;

`ifdef ARMLEOCPU_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [33:0] m0_address, m1_address, s_address;
  logic [4:0]  m0_burstcount, m1_burstcount, s_burstcount;
  logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic        m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic [1:0]  m0_response, m1_response, s_response;

  armleocpu_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
    .m0_readdata(m0_readdata), .m0_response(m0_response),
    .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
    .m1_readdata(m1_readdata), .m1_response(m1_response),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid),
    .s_readdata(s_readdata), .s_response(s_response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m0r, m0w, m1r, m1w;
    logic [4:0] bc;
    logic       sw, srdv;
    logic       e_sr, e_sw, e_m0wait, e_m1wait, e_m0rdv, e_m1rdv;
    logic [33:0] e_addr;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   rand_done = 1'b0;
  bit   m0_collecting = 1'b0;
  bit   m1_collecting = 1'b0;
  logic [31:0] mem    [64];
  logic [31:0] shadow [64];

  task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, 34'(act), 34'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] initWord(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0101_0011;
  endfunction

  function automatic vec_t mk(input logic m0r, m0w, m1r, m1w, input logic [4:0] bc,
                              input logic sw, srdv, e_sr, e_sw, e0w, e1w, e0v, e1v,
                              input logic [33:0] ea);
    vec_t v;
    v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w; v.bc = bc;
    v.sw = sw; v.srdv = srdv; v.e_sr = e_sr; v.e_sw = e_sw;
    v.e_m0wait = e0w; v.e_m1wait = e1w; v.e_m0rdv = e0v; v.e_m1rdv = e1v; v.e_addr = ea;
    return v;
  endfunction

  task automatic idleInputs();
    m0_address = '0; m0_burstcount = '0; m0_read = 1'b0; m0_write = 1'b0;
    m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_burstcount = '0; m1_read = 1'b0; m1_write = 1'b0;
    m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0; s_response = '0;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    idleInputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    m0_address = 34'h1000; m1_address = 34'h2000;
    m0_read = v.m0r; m0_write = v.m0w; m1_read = v.m1r; m1_write = v.m1w;
    m0_burstcount = v.bc; m1_burstcount = v.bc;
    s_waitrequest = v.sw; s_readdatavalid = v.srdv;
  endtask

  // Non-collecting master must never see a read beat during random traffic.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!m0_collecting) checkBit("m0 stray readdatavalid", m0_readdatavalid, 1'b0);
      if (!m1_collecting) checkBit("m1 stray readdatavalid", m1_readdatavalid, 1'b0);
    end
  end

  // Memory slave: random waitrequest, read beats with random gaps.
  task automatic slaveLoop();
    int rd_base, rd_left, wr_base, wr_left;
    rd_base = 0; rd_left = 0; wr_base = 0; wr_left = 0;
    while (!rand_done) begin
      s_waitrequest = ($urandom_range(0, 2) == 0);
      s_response = 2'b00;
      if (rd_left > 0 && $urandom_range(0, 1) == 1) begin
        s_readdatavalid = 1'b1;
        s_readdata = mem[rd_base];
        rd_base++;
        rd_left--;
      end else begin
        s_readdatavalid = 1'b0;
        s_readdata = $urandom;
      end
      @(negedge clk);
      if (s_read && !s_waitrequest) begin
        rd_base = int'(s_address[7:2]);
        rd_left = (s_burstcount == 5'd0) ? 1 : int'(s_burstcount);
      end else if (s_write && !s_waitrequest) begin
        if (wr_left == 0) begin
          wr_base = int'(s_address[7:2]);
          wr_left = (s_burstcount == 5'd0) ? 1 : int'(s_burstcount);
        end
        mem[wr_base] = s_writedata;
        wr_base++;
        wr_left--;
      end
      tick();
    end
    s_readdatavalid = 1'b0;
    s_waitrequest = 1'b0;
  endtask

  task automatic m0Driver(input int n);
    int idx, bc, beats, got;
    bit acc;
    for (int t = 0; t < n; t++) begin
      idx = $urandom_range(0, 28);
      bc = $urandom_range(0, 4);
      beats = (bc == 0) ? 1 : bc;
      m0_address = 34'(idx * 4); m0_burstcount = 5'(bc); m0_read = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 400 && !acc; c++) begin
        @(negedge clk);
        acc = !m0_waitrequest;
        tick();
      end
      m0_read = 1'b0;
      checkBit("m0 rand accept", acc, 1'b1);
      if (acc) begin
        m0_collecting = 1'b1;
        got = 0;
        for (int c = 0; c < 400 && got < beats; c++) begin
          @(negedge clk);
          if (m0_readdatavalid) begin
            checkOutput("m0 rand readdata", 34'(m0_readdata), 34'(initWord(idx + got)));
            got++;
          end
          tick();
        end
        m0_collecting = 1'b0;
        checkOutput("m0 rand beat count", 34'(got), 34'(beats));
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic m1Driver(input int n);
    int idx, bc, beats, got;
    bit acc, ok_all;
    logic [31:0] wd [4];
    for (int t = 0; t < n; t++) begin
      idx = 32 + $urandom_range(0, 28);
      bc = $urandom_range(0, 4);
      beats = (bc == 0) ? 1 : bc;
      m1_address = 34'(idx * 4); m1_burstcount = 5'(bc);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) wd[k] = $urandom;
        m1_byteenable = 4'hF;
        ok_all = 1'b1;
        for (int k = 0; k < beats && ok_all; k++) begin
          m1_writedata = wd[k];
          m1_write = 1'b1;
          acc = 1'b0;
          for (int c = 0; c < 400 && !acc; c++) begin
            @(negedge clk);
            acc = !m1_waitrequest;
            tick();
          end
          if (!acc) ok_all = 1'b0;
        end
        m1_write = 1'b0;
        checkBit("m1 rand write accept", ok_all, 1'b1);
        for (int k = 0; k < beats; k++) shadow[idx + k] = wd[k];
      end else begin
        m1_read = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 400 && !acc; c++) begin
          @(negedge clk);
          acc = !m1_waitrequest;
          tick();
        end
        m1_read = 1'b0;
        checkBit("m1 rand read accept", acc, 1'b1);
        if (acc) begin
          m1_collecting = 1'b1;
          got = 0;
          for (int c = 0; c < 400 && got < beats; c++) begin
            @(negedge clk);
            if (m1_readdatavalid) begin
              checkOutput("m1 rand readdata", 34'(m1_readdata), 34'(shadow[idx + got]));
              got++;
            end
            tick();
          end
          m1_collecting = 1'b0;
          checkOutput("m1 rand beat count", 34'(got), 34'(beats));
        end
      end
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  initial begin
    vec_t tbl [19];
    logic g;
    int granted, exp_g;

    g = RR ? 1'b0 : 1'b1;
    tbl[0]  = mk(1,0,0,0, 5'd1, 0,0,  0,0, 1,1, 0,0, 34'h0);
    tbl[1]  = mk(1,0,0,0, 5'd1, 0,0,  1,0, 0,1, 0,0, 34'h1000);
    tbl[2]  = mk(0,0,0,0, 5'd1, 0,0,  0,0, 1,1, 0,0, 34'h0);
    tbl[3]  = mk(0,0,0,0, 5'd1, 0,1,  0,0, 1,1, 1,0, 34'h0);
    tbl[4]  = mk(0,0,0,0, 5'd1, 0,1,  0,0, 1,1, 0,0, 34'h0);
    tbl[5]  = mk(0,0,0,1, 5'd2, 1,0,  0,0, 1,1, 0,0, 34'h0);
    tbl[6]  = mk(0,0,0,1, 5'd2, 1,1,  0,1, 1,1, 0,0, 34'h2000);
    tbl[7]  = mk(0,0,0,1, 5'd2, 0,0,  0,1, 1,0, 0,0, 34'h2000);
    tbl[8]  = mk(0,0,0,1, 5'd2, 0,1,  0,1, 1,0, 0,0, 34'h2000);
    tbl[9]  = mk(0,0,0,0, 5'd1, 0,0,  0,0, 1,1, 0,0, 34'h0);
    tbl[10] = mk(1,0,1,0, 5'd1, 0,0,  0,0, 1,1, 0,0, 34'h0);
    tbl[11] = mk(1,0,1,0, 5'd1, 0,0,  1,0, g,!g, 0,0, g ? 34'h2000 : 34'h1000);
    tbl[12] = mk(0,0,0,0, 5'd1, 0,1,  0,0, 1,1, !g,g, 34'h0);
    tbl[13] = mk(0,0,0,0, 5'd1, 0,0,  0,0, 1,1, 0,0, 34'h0);
    tbl[14] = mk(1,1,0,0, 5'd1, 1,0,  0,0, 1,1, 0,0, 34'h0);
    tbl[15] = mk(1,1,0,0, 5'd1, 1,0,  1,0, 1,1, 0,0, 34'h1000);
    tbl[16] = mk(1,1,0,0, 5'd1, 0,0,  1,0, 0,1, 0,0, 34'h1000);
    tbl[17] = mk(0,0,0,0, 5'd1, 0,1,  0,0, 1,1, 1,0, 34'h0);
    tbl[18] = mk(0,0,0,0, 5'd1, 0,0,  0,0, 1,1, 0,0, 34'h0);

    // Outputs held safe while reset is asserted, even with requests pending.
    rst_n = 1'b0;
    idleInputs();
    m0_read = 1'b1; m1_write = 1'b1;
    @(negedge clk);
    checkBit("reset s_read", s_read, 1'b0);
    checkBit("reset s_write", s_write, 1'b0);
    checkBit("reset m0_waitrequest", m0_waitrequest, 1'b1);
    checkBit("reset m1_waitrequest", m1_waitrequest, 1'b1);
    tick();
    idleInputs();
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkBit($sformatf("vec%0d s_read", i), s_read, tbl[i].e_sr);
      checkBit($sformatf("vec%0d s_write", i), s_write, tbl[i].e_sw);
      checkBit($sformatf("vec%0d m0_waitrequest", i), m0_waitrequest, tbl[i].e_m0wait);
      checkBit($sformatf("vec%0d m1_waitrequest", i), m1_waitrequest, tbl[i].e_m1wait);
      checkBit($sformatf("vec%0d m0_readdatavalid", i), m0_readdatavalid, tbl[i].e_m0rdv);
      checkBit($sformatf("vec%0d m1_readdatavalid", i), m1_readdatavalid, tbl[i].e_m1rdv);
      if (tbl[i].e_sr || tbl[i].e_sw)
        checkOutput($sformatf("vec%0d s_address", i), s_address, tbl[i].e_addr);
      tick();
    end

    // m1 read burst of 16: s_read forced low in RDATA even while m1_read stays high.
    applyReset();
    m1_address = 34'h2000; m1_burstcount = 5'd16; m1_read = 1'b1;
    @(negedge clk);
    checkBit("A idle s_read", s_read, 1'b0);
    tick();
    @(negedge clk);
    checkBit("A cmd s_read", s_read, 1'b1);
    checkOutput("A cmd s_address", s_address, 34'h2000);
    checkOutput("A cmd s_burstcount", 34'(s_burstcount), 34'd16);
    tick();
    for (int b = 0; b < 16; b++) begin
      s_readdatavalid = 1'b1;
      s_readdata = 32'hD000_0000 + 32'(b);
      @(negedge clk);
      checkBit("A rdata s_read", s_read, 1'b0);
      checkBit("A m1 readdatavalid", m1_readdatavalid, 1'b1);
      checkBit("A m0 readdatavalid", m0_readdatavalid, 1'b0);
      checkOutput("A m1 readdata", 34'(m1_readdata), 34'(32'hD000_0000 + 32'(b)));
      tick();
      m1_read = 1'b0;
    end
    @(negedge clk);
    checkBit("A beat after burst m1 readdatavalid", m1_readdatavalid, 1'b0);
    tick();
    s_readdatavalid = 1'b0;

    // m1 write burst of 4 with a stall on every beat, then m0 must be served.
    applyReset();
    m1_address = 34'h2000; m1_burstcount = 5'd4; m1_byteenable = 4'hF; m1_write = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      m1_writedata = 32'h0000_0100 + 32'(k);
      s_waitrequest = 1'b1;
      @(negedge clk);
      checkBit("B stall s_write", s_write, 1'b1);
      checkBit("B stall m1_waitrequest", m1_waitrequest, 1'b1);
      tick();
      s_waitrequest = 1'b0;
      @(negedge clk);
      checkBit("B beat s_write", s_write, 1'b1);
      checkBit("B beat s_read", s_read, 1'b0);
      checkBit("B beat m1_waitrequest", m1_waitrequest, 1'b0);
      checkOutput("B beat s_writedata", 34'(s_writedata), 34'(32'h0000_0100 + 32'(k)));
      checkOutput("B beat s_byteenable", 34'(s_byteenable), 34'hF);
      tick();
    end
    m1_write = 1'b0;
    m0_address = 34'h1000; m0_burstcount = 5'd1; m0_read = 1'b1;
    @(negedge clk);
    checkBit("B after burst s_write", s_write, 1'b0);
    tick();
    @(negedge clk);
    checkBit("B next request s_read", s_read, 1'b1);
    checkOutput("B next request s_address", s_address, 34'h1000);

    // Four rounds of simultaneous single-beat reads.
    applyReset();
    m0_address = 34'h1000; m1_address = 34'h2000;
    m0_burstcount = 5'd1; m1_burstcount = 5'd1;
    for (int r = 0; r < 4; r++) begin
      m0_read = 1'b1; m1_read = 1'b1;
      tick();
      @(negedge clk);
      granted = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : 2);
      exp_g = RR ? (r % 2) : 1;
      checkOutput($sformatf("C grant round %0d", r), 34'(granted), 34'(exp_g));
      checkOutput("C s_address", s_address, (exp_g == 1) ? 34'h2000 : 34'h1000);
      tick();
      m0_read = 1'b0; m1_read = 1'b0; s_readdatavalid = 1'b1;
      @(negedge clk);
      checkBit("C m0 readdatavalid", m0_readdatavalid, exp_g == 0);
      checkBit("C m1 readdatavalid", m1_readdatavalid, exp_g == 1);
      tick();
      s_readdatavalid = 1'b0;
    end

    // Error response on beat 2 of 4 passes through and the burst runs to the end.
    applyReset();
    m0_address = 34'h1000; m0_burstcount = 5'd4; m0_read = 1'b1;
    tick();
    tick();
    m0_read = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      s_readdatavalid = 1'b1;
      s_response = (b == 2) ? 2'b11 : 2'b00;
      s_readdata = 32'h0000_0E00 + 32'(b);
      @(negedge clk);
      checkBit("D m0 readdatavalid", m0_readdatavalid, 1'b1);
      checkBit("D m1 readdatavalid", m1_readdatavalid, 1'b0);
      checkOutput("D m0_response", 34'(m0_response), (b == 2) ? 34'd3 : 34'd0);
      checkOutput("D m1_response", 34'(m1_response), (b == 2) ? 34'd3 : 34'd0);
      checkOutput("D m0_readdata", 34'(m0_readdata), 34'(32'h0000_0E00 + 32'(b)));
      tick();
      if (b == 2) begin
        s_readdatavalid = 1'b0;
        s_response = 2'b00;
        tick();
      end
    end
    s_response = 2'b00;
    @(negedge clk);
    checkBit("D beat after burst m0 readdatavalid", m0_readdatavalid, 1'b0);
    tick();
    s_readdatavalid = 1'b0;

    // Reset lands on beat 3 of 8; nothing of the old burst may survive.
    applyReset();
    m0_address = 34'h3000; m0_burstcount = 5'd8; m0_read = 1'b1;
    tick();
    tick();
    m0_read = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_readdatavalid = 1'b1;
      @(negedge clk);
      checkBit("E early beat m0 readdatavalid", m0_readdatavalid, 1'b1);
      tick();
    end
    s_readdatavalid = 1'b1;
    m0_read = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkBit("E reset m0_readdatavalid", m0_readdatavalid, 1'b0);
    checkBit("E reset m0_waitrequest", m0_waitrequest, 1'b1);
    checkBit("E reset m1_waitrequest", m1_waitrequest, 1'b1);
    checkBit("E reset s_read", s_read, 1'b0);
    tick();
    rst_n = 1'b1;
    m0_read = 1'b0;
    @(negedge clk);
    checkBit("E after reset stray m0_readdatavalid", m0_readdatavalid, 1'b0);
    tick();
    s_readdatavalid = 1'b0;
    m1_address = 34'h2000; m1_burstcount = 5'd1; m1_read = 1'b1;
    tick();
    @(negedge clk);
    checkBit("E new request s_read", s_read, 1'b1);
    checkOutput("E new request s_address", s_address, 34'h2000);
    tick();
    m1_read = 1'b0;
    s_readdatavalid = 1'b1;
    @(negedge clk);
    checkBit("E new request m1_readdatavalid", m1_readdatavalid, 1'b1);
    tick();
    s_readdatavalid = 1'b0;

    // Randomized traffic from both masters against the memory model.
    applyReset();
    for (int i = 0; i < 64; i++) begin
      mem[i] = initWord(i);
      shadow[i] = initWord(i);
    end
    mon_en = 1'b1;
    fork
      begin
        fork
          m0Driver(30);
          m1Driver(30);
        join
        rand_done = 1'b1;
      end
      slaveLoop();
    join
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
